// File: rtl/picorv32_irq_timer_ctrl.sv
// picorv32_irq_timer_ctrl: Wishbone-mapped reloadable timer and edge-triggered
// interrupt controller driving the picorv32 irq vector.
module picorv32_irq_timer_ctrl #(
    parameter int N_EXT         = 4,
    parameter int TIMER_IRQ_BIT = 4,
    parameter int EXT_IRQ_BASE  = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             wb_cyc_i,
    input  logic             wb_stb_i,
    input  logic             wb_we_i,
    input  logic [2:0]       wb_adr_i,
    input  logic [3:0]       wb_sel_i,
    input  logic [31:0]      wb_dat_i,
    output logic [31:0]      wb_dat_o,
    output logic             wb_ack_o,
    input  logic [N_EXT-1:0] ext_irq_i,
    output logic [31:0]      irq_o,
    output logic             timer_tick_o
);

    logic             r_ack;
    logic [31:0]      r_dat;
    logic             r_en;
    logic             r_ar;
    logic [31:0]      r_reload;
    logic [31:0]      r_count;
    logic [31:0]      r_pend;
    logic [31:0]      r_mask;
    logic [31:0]      r_irq;
    logic             r_tick;
    logic [N_EXT-1:0] r_sync1;
    logic [N_EXT-1:0] r_sync2;
    logic [N_EXT-1:0] r_prev;

    logic             w_req;
    logic             w_wr_ctrl;
    logic             w_wr_reload;
    logic             w_wr_pend;
    logic             w_wr_mask;
    logic             w_expire;
    logic [31:0]      w_lane;
    logic [31:0]      w_reload_new;
    logic [31:0]      w_mask_new;
    logic [31:0]      w_w1c;
    logic [31:0]      w_set;
    logic [31:0]      w_rdata;
    logic [N_EXT-1:0] w_rise;

    assign w_req       = wb_cyc_i & wb_stb_i & ~r_ack;
    assign w_wr_ctrl   = w_req & wb_we_i & (wb_adr_i == 3'd0);
    assign w_wr_reload = w_req & wb_we_i & (wb_adr_i == 3'd1);
    assign w_wr_pend   = w_req & wb_we_i & (wb_adr_i == 3'd3);
    assign w_wr_mask   = w_req & wb_we_i & (wb_adr_i == 3'd4);

    assign w_lane = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}},
                     {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
    assign w_reload_new = (r_reload & ~w_lane) | (wb_dat_i & w_lane);
    assign w_mask_new   = (r_mask & ~w_lane) | (wb_dat_i & w_lane);
    assign w_w1c        = w_wr_pend ? (wb_dat_i & w_lane) : 32'd0;

    assign w_expire = r_en & (r_count == 32'd0);
    assign w_rise   = r_sync2 & ~r_prev;

    always_comb begin
        w_set = '0;
        w_set[TIMER_IRQ_BIT] = w_expire;
        for (int i = 0; i < N_EXT; i++) begin
            w_set[EXT_IRQ_BASE + i] = w_rise[i];
        end
    end

    always_comb begin
        w_rdata = '0;
        case (wb_adr_i)
            3'd0:    w_rdata = {30'd0, r_ar, r_en};
            3'd1:    w_rdata = r_reload;
            3'd2:    w_rdata = r_count;
            3'd3:    w_rdata = r_pend;
            3'd4:    w_rdata = r_mask;
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_ack   <= 1'b0;
            r_dat   <= '0;
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
            r_pend  <= '0;
            r_mask  <= '0;
            r_irq   <= '0;
        end else begin
            r_ack   <= w_req;
            r_dat   <= (w_req && !wb_we_i) ? w_rdata : 32'd0;
            r_sync1 <= ext_irq_i;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            // set sources override a simultaneous write-1-to-clear
            r_pend  <= (r_pend & ~w_w1c) | w_set;
            r_irq   <= r_pend & r_mask;
            if (w_wr_mask) r_mask <= w_mask_new;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_en     <= 1'b0;
            r_ar     <= 1'b0;
            r_reload <= '0;
            r_count  <= '0;
            r_tick   <= 1'b0;
        end else begin
            r_tick <= w_expire;
            if (w_wr_ctrl && wb_sel_i[0]) begin
                r_en <= wb_dat_i[0];
                r_ar <= wb_dat_i[1];
            end else if (w_expire && !r_ar) begin
                r_en <= 1'b0;
            end
            if (w_wr_reload) r_reload <= w_reload_new;
            if (w_wr_reload) begin
                r_count <= w_reload_new;
            end else if (r_en) begin
                if (r_count == 32'd0) r_count <= r_ar ? r_reload : 32'd0;
                else                  r_count <= r_count - 32'd1;
            end
        end
    end

    assign wb_ack_o     = r_ack;
    assign wb_dat_o     = r_dat;
    assign irq_o        = r_irq;
    assign timer_tick_o = r_tick;

endmodule

// File: tb/tb_picorv32_irq_timer_ctrl.sv
// Scoreboard bench for picorv32_irq_timer_ctrl: reference model predicts each
// Wishbone read and per-cycle irq/tick; a monitor compares on every ack.
module tb_picorv32_irq_timer_ctrl;

    localparam int TBIT = 4;
    localparam int EBASE = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cyc, stb, we;
    logic [2:0]  adr;
    logic [3:0]  sel;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic        ack;
    logic [3:0]  ext;
    logic [31:0] irq;
    logic        tick;

    int total = 0;
    int bad = 0;

    picorv32_irq_timer_ctrl #(
        .N_EXT(4), .TIMER_IRQ_BIT(TBIT), .EXT_IRQ_BASE(EBASE)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
        .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(dat_w),
        .wb_dat_o(dat_r), .wb_ack_o(ack),
        .ext_irq_i(ext), .irq_o(irq), .timer_tick_o(tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rd;
        logic [31:0] data;
    } exp_t;
    exp_t q[$];

    // reference model state
    bit          m_en, m_ar, m_ack, m_tick;
    logic [31:0] m_reload, m_count, m_pend, m_mask, m_irq;
    logic [3:0]  m_s1, m_s2, m_prev;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] lanes(input logic [31:0] old,
                                          input logic [31:0] v,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = v[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_read(input logic [2:0] a);
        if (a == 0) return {30'd0, m_ar, m_en};
        if (a == 1) return m_reload;
        if (a == 2) return m_count;
        if (a == 3) return m_pend;
        if (a == 4) return m_mask;
        return 32'd0;
    endfunction

    always @(posedge clk) begin : model
        bit          req, expire, n_en, n_ar;
        logic [31:0] n_count, n_reload, n_mask, clr, set;
        exp_t        e;
        if (!rst_n) begin
            m_en = 0; m_ar = 0; m_ack = 0; m_tick = 0;
            m_reload = 0; m_count = 0; m_pend = 0; m_mask = 0; m_irq = 0;
            m_s1 = 0; m_s2 = 0; m_prev = 0;
            q.delete();
        end else begin
            req = cyc && stb && !m_ack;
            expire = m_en && (m_count == 0);
            set = 0;
            if (expire) set[TBIT] = 1'b1;
            for (int i = 0; i < 4; i++)
                if (m_s2[i] && !m_prev[i]) set[EBASE + i] = 1'b1;
            if (req) begin
                e.rd = !we;
                e.data = model_read(adr);
                q.push_back(e);
            end
            n_en = m_en; n_ar = m_ar; n_count = m_count;
            n_reload = m_reload; n_mask = m_mask; clr = 0;
            if (m_en) begin
                if (m_count == 0) n_count = m_ar ? m_reload : 0;
                else n_count = m_count - 1;
                if (expire && !m_ar) n_en = 0;
            end
            if (req && we) begin
                if (adr == 0 && sel[0]) begin
                    n_en = dat_w[0];
                    n_ar = dat_w[1];
                end
                if (adr == 1) begin
                    n_reload = lanes(m_reload, dat_w, sel);
                    n_count = n_reload;
                end
                if (adr == 3) clr = lanes(32'd0, dat_w, sel);
                if (adr == 4) n_mask = lanes(m_mask, dat_w, sel);
            end
            m_irq = m_pend & m_mask;
            m_pend = (m_pend & ~clr) | set;
            m_tick = expire;
            m_ack = req;
            m_en = n_en; m_ar = n_ar; m_count = n_count;
            m_reload = n_reload; m_mask = n_mask;
            m_prev = m_s2; m_s2 = m_s1; m_s1 = ext;
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        check("ack", {31'd0, ack}, {31'd0, m_ack});
        check("tick", {31'd0, tick}, {31'd0, m_tick});
        check("irq", irq, m_irq);
        if (ack) begin
            if (q.size() == 0) begin
                check("orphan_ack", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                if (e.rd) check("rdata", dat_r, e.data);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic xfer(input bit w, input logic [2:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        input bit hold, output logic [31:0] rd);
        @(negedge clk);
        cyc = 1; stb = 1; we = w; adr = a; dat_w = d; sel = s;
        @(negedge clk);
        #1;
        check("xfer_ack", {31'd0, ack}, 32'd1);
        rd = dat_r;
        if (hold) @(negedge clk);
        cyc = 0; stb = 0; we = 0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        logic [31:0] unused;
        xfer(1'b1, a, d, 4'hF, 1'b0, unused);
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        xfer(1'b0, a, 32'd0, 4'hF, 1'b0, d);
    endtask

    initial begin
        logic [31:0] v;
        int n;
        rst_n = 0; cyc = 0; stb = 0; we = 0;
        adr = 0; sel = 0; dat_w = 0; ext = 0;
        idle(3);
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_dat", dat_r, 32'd0);
        check("rst_irq", irq, 32'd0);
        check("rst_tick", {31'd0, tick}, 32'd0);
        #3 rst_n = 1;
        idle(3);
        check("post_rst_irq", irq, 32'd0);

        wr(3'd1, 32'd9);
        wr(3'd4, 32'h10);
        wr(3'd0, 32'd3);
        idle(5);
        n = 0;
        repeat (40) begin
            @(negedge clk);
            #1;
            if (tick) n++;
        end
        check("period10_ticks", n, 4);
        wr(3'd0, 32'd0);
        wr(3'd3, 32'hFFFF_FFFF);

        wr(3'd1, 32'd5);
        wr(3'd0, 32'd1);
        idle(12);
        rd(3'd0, v);
        check("oneshot_ctrl", v, 32'd0);
        rd(3'd2, v);
        check("oneshot_count", v, 32'd0);
        wr(3'd3, 32'hFFFF_FFFF);

        wr(3'd4, 32'h400);
        @(negedge clk);
        ext[2] = 1;
        idle(50);
        rd(3'd3, v);
        check("ext_pending", v, 32'h400);
        check("ext_irq10", {31'd0, irq[10]}, 32'd1);
        wr(3'd3, 32'h400);
        idle(2);
        check("ext_cleared", {31'd0, irq[10]}, 32'd0);
        ext[2] = 0;

        wr(3'd4, 32'h10);
        wr(3'd1, 32'd0);
        wr(3'd0, 32'd3);
        wr(3'd3, 32'h10);
        wr(3'd3, 32'h10);
        rd(3'd3, v);
        check("w1c_vs_set", v & 32'h10, 32'h10);
        wr(3'd0, 32'd0);

        wr(3'd4, 32'd0);
        xfer(1'b1, 3'd4, 32'hFFFF_FFFF, 4'b0010, 1'b0, v);
        rd(3'd4, v);
        check("byte_mask", v, 32'h0000_FF00);
        wr(3'd6, 32'hDEAD_BEEF);
        rd(3'd6, v);
        check("adr6_zero", v, 32'd0);

        wr(3'd4, 32'hFFFF_FFFF);
        wr(3'd1, 32'd3);
        wr(3'd0, 32'd3);
        idle(8);
        @(negedge clk);
        cyc = 1; stb = 1; we = 0; adr = 3'd2;
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        check("midrst_ack", {31'd0, ack}, 32'd0);
        check("midrst_irq", irq, 32'd0);
        cyc = 0; stb = 0;
        idle(2);
        #3 rst_n = 1;
        idle(2);

        for (int k = 0; k < 300; k++) begin
            logic [2:0]  a;
            logic [31:0] d;
            a = 3'($urandom_range(0, 7));
            d = $urandom;
            if (a == 3'd1) d = d & 32'h1F;
            if (a == 3'd0) d = d & 32'h3;
            xfer(1'($urandom_range(0, 1)), a, d, 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 7) == 0), v);
            if ($urandom_range(0, 3) == 0) ext = 4'($urandom_range(0, 15));
            idle($urandom_range(0, 3));
        end
        idle(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
